// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - start/busy/done bus for the bit-serial adder/subtractor
//
// Purpose: groups the request operands and the completion outputs of
//          serial_add_sub so a requester connects through one port.
// Signals:
//   start   request, sampled by the unit only when not busy
//   mode    0 = add (a+b), 1 = subtract (a-b)
//   a, b    WIDTH-bit operands, captured with start
//   busy    high while bits are being processed
//   done    one-cycle pulse when result and flags are valid
//   result  WIDTH-bit sum or difference
//   cout    add: carry out, sub: borrow out
//   ovf     two's complement overflow
//   zero    result == 0
// Modports: master drives the request, slave is the arithmetic unit.

interface serial_add_sub_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial N-bit adder/subtractor, one bit per clock, LSB first
//
// Purpose: computes a+b or a-b through a single full-add/full-subtract slice
//          with a registered carry/borrow. An operation takes WIDTH cycles in
//          RUN followed by a one-cycle DONE; a new start is accepted in IDLE
//          or DONE, giving one operation every WIDTH+1 cycles back to back.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; aborts any operation in flight
//   bus     serial_add_sub_if slave: start/mode/a/b in, busy/done/result/
//           cout/ovf/zero out

module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_add_sub_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;

    // Operand shift registers: bit i sits at position 0 during step i.
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    // The shift registers lose their MSBs, so the sign bits are kept for ovf.
    logic             a_msb;
    logic             b_msb;
    logic             sub_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    // Result bits accumulate here so the visible result only changes at completion.
    logic [WIDTH-1:0] acc;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             ai;
    logic             bi;
    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] acc_next;
    logic             last_bit;
    logic             ovf_next;

    always_comb begin
        ai       = sh_a[0];
        bi       = sh_b[0];
        // Sum and difference bits are the same three-input xor.
        sum_bit  = ai ^ bi ^ carry;
        if (sub_q) begin
            carry_next = (~ai & bi) | (carry & ~(ai ^ bi));
        end else begin
            carry_next = (ai & bi) | (carry & (ai ^ bi));
        end
        // Each new bit enters from the MSB side; after WIDTH shifts bit 0 is at the LSB.
        acc_next = {sum_bit, acc[WIDTH-1:1]};
        last_bit = (cnt == CNT_W'(WIDTH - 1));
        // On the last step sum_bit is the result MSB.
        if (sub_q) begin
            ovf_next = (a_msb != b_msb) && (sum_bit != a_msb);
        end else begin
            ovf_next = (a_msb == b_msb) && (sum_bit != a_msb);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            sub_q    <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sh_a   <= bus.a;
                        sh_b   <= bus.b;
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        sub_q  <= bus.mode;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        acc    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end

                RUN: begin
                    // start is ignored here; the operation in flight is untouched.
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= carry_next;
                    acc   <= acc_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= acc_next;
                        cout_q   <= carry_next;
                        ovf_q    <= ovf_next;
                        zero_q   <= (acc_next == '0);
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - scoreboard bench for serial_add_sub at WIDTH 8, 4 and 16

module tb_serial_add_sub;

    typedef struct {
        logic [15:0] result;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    exp_t q8[$];
    exp_t q4[$];
    exp_t q16[$];

    serial_add_sub_if #(.WIDTH(8))  bus8 ();
    serial_add_sub_if #(.WIDTH(4))  bus4 ();
    serial_add_sub_if #(.WIDTH(16)) bus16 ();

    serial_add_sub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    serial_add_sub #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    serial_add_sub #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: integer arithmetic, signed overflow by range test.
    function automatic exp_t model(input int w, input bit m, input int a, input int b);
        exp_t r;
        int   modv;
        int   full;
        int   sa;
        int   sb;
        int   t;
        modv     = 1 << w;
        full     = m ? a - b : a + b;
        r.result = 16'((full + modv) % modv);
        r.cout   = m ? (a < b) : (full >= modv);
        sa       = (a >= modv / 2) ? a - modv : a;
        sb       = (b >= modv / 2) ? b - modv : b;
        t        = m ? sa - sb : sa + sb;
        r.ovf    = (t >= modv / 2) || (t < -(modv / 2));
        r.zero   = (r.result == 16'd0);
        return r;
    endfunction

    // Drive one request; operands are scrambled after capture to prove they are latched.
    task automatic drive8(input bit m, input logic [7:0] a, input logic [7:0] b);
        bus8.mode  = m;
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        q8.push_back(model(8, m, int'(a), int'(b)));
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
        bus8.mode  = ~m;
    endtask

    task automatic drive4(input bit m, input logic [3:0] a, input logic [3:0] b);
        bus4.mode  = m;
        bus4.a     = a;
        bus4.b     = b;
        bus4.start = 1'b1;
        q4.push_back(model(4, m, int'(a), int'(b)));
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus4.a     = ~a;
        bus4.b     = ~b;
        bus4.mode  = ~m;
    endtask

    task automatic drive16(input bit m, input logic [15:0] a, input logic [15:0] b);
        bus16.mode  = m;
        bus16.a     = a;
        bus16.b     = b;
        bus16.start = 1'b1;
        q16.push_back(model(16, m, int'(a), int'(b)));
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        bus16.a     = ~a;
        bus16.b     = ~b;
        bus16.mode  = ~m;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q8.size() + q4.size() + q16.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("drain_timeout", 32'(q8.size() + q4.size() + q16.size()), 32'd0);
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (bus8.done) begin
            if (q8.size() == 0) begin
                check("w8_spurious_done", 32'(bus8.done), 32'd0);
            end else begin
                e = q8.pop_front();
                check("w8_result", 32'(bus8.result), 32'(e.result));
                check("w8_cout",   32'(bus8.cout),   32'(e.cout));
                check("w8_ovf",    32'(bus8.ovf),    32'(e.ovf));
                check("w8_zero",   32'(bus8.zero),   32'(e.zero));
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (bus4.done) begin
            if (q4.size() == 0) begin
                check("w4_spurious_done", 32'(bus4.done), 32'd0);
            end else begin
                e = q4.pop_front();
                check("w4_result", 32'(bus4.result), 32'(e.result));
                check("w4_cout",   32'(bus4.cout),   32'(e.cout));
                check("w4_ovf",    32'(bus4.ovf),    32'(e.ovf));
                check("w4_zero",   32'(bus4.zero),   32'(e.zero));
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (bus16.done) begin
            if (q16.size() == 0) begin
                check("w16_spurious_done", 32'(bus16.done), 32'd0);
            end else begin
                e = q16.pop_front();
                check("w16_result", 32'(bus16.result), 32'(e.result));
                check("w16_cout",   32'(bus16.cout),   32'(e.cout));
                check("w16_ovf",    32'(bus16.ovf),    32'(e.ovf));
                check("w16_zero",   32'(bus16.zero),   32'(e.zero));
            end
        end
    end

    initial begin
        int cycles;
        int busy_n;
        int n;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus8.start  = 1'b0; bus8.mode  = 1'b0; bus8.a  = '0; bus8.b  = '0;
        bus4.start  = 1'b0; bus4.mode  = 1'b0; bus4.a  = '0; bus4.b  = '0;
        bus16.start = 1'b0; bus16.mode = 1'b0; bus16.a = '0; bus16.b = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(bus8.busy),   32'd0);
        check("rst_done",   32'(bus8.done),   32'd0);
        check("rst_result", 32'(bus8.result), 32'd0);
        check("rst_cout",   32'(bus8.cout),   32'd0);
        check("rst_ovf",    32'(bus8.ovf),    32'd0);
        check("rst_zero",   32'(bus8.zero),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency and busy width on 0x05-0x03.
        drive8(1'b1, 8'h05, 8'h03);
        cycles = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (bus8.busy) busy_n++;
        end while (!bus8.done && cycles < 40);
        check("done_latency", 32'(cycles - 1), 32'd8);
        check("busy_cycles",  32'(busy_n),     32'd8);
        drain(40);

        drive8(1'b1, 8'h03, 8'h05); drain(40);
        drive8(1'b1, 8'h80, 8'h01); drain(40);
        drive8(1'b0, 8'hFF, 8'h01); drain(40);
        drive8(1'b0, 8'h7F, 8'h01); drain(40);

        // Start while busy is ignored; the previous result stays visible during RUN.
        drive8(1'b1, 8'h10, 8'h01);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("hold_result", 32'(bus8.result), 32'h80);
        bus8.start = 1'b1;
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
        bus8.mode  = 1'b0;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        n = 0;
        while (!bus8.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ignore_done_seen", 32'(bus8.done), 32'd1);
        // Back-to-back: start raised in the DONE cycle.
        drive8(1'b0, 8'h20, 8'h22);
        check("b2b_busy", 32'(bus8.busy), 32'd1);
        drain(40);

        // Reset in RUN cycle 4 aborts with no done.
        drive8(1'b0, 8'h33, 8'h44);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        q8.delete();
        #1;
        check("midrst_busy",   32'(bus8.busy),   32'd0);
        check("midrst_done",   32'(bus8.done),   32'd0);
        check("midrst_result", 32'(bus8.result), 32'd0);
        check("midrst_cout",   32'(bus8.cout),   32'd0);
        check("midrst_ovf",    32'(bus8.ovf),    32'd0);
        check("midrst_zero",   32'(bus8.zero),   32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        drive8(1'b0, 8'h09, 8'h06);
        drain(40);

        drive16(1'b1, 16'h0000, 16'h0001);
        drain(60);

        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    drive4(m[0], 4'(a), 4'(b));
                    drain(30);
                end
            end
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
